matrix_vector_mac: RTL and testbench

Parametrised, sequential matrix-vector multiplier. It computes result = M·v for an N×N matrix of DATA_W-bit elements and an N-element vector. The computation is column-serial: N multiply-accumulate lanes, one matrix column per cycle. Signed and unsigned operands are selectable per transaction. Valid/ready handshakes on input and output let it sit between a stream source and a result consumer. It is the successor of the fixed 3×3, 8-bit, unsigned matrix-vector multiplier; the default parameters reproduce that configuration with widened, overflow-free results.

---
 rtl/mvm_pkg.sv | 11 +
 rtl/mvm_col_mac.sv | 44 ++++
 rtl/matrix_vector_mac.sv | 104 ++++++++++
 tb/tb_matrix_vector_mac.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/mvm_pkg.sv
// rtl/mvm_pkg.sv - shared state type and width helper for matrix_vector_mac
package mvm_pkg;

  typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;

  // Smallest lane width that holds a full N-term dot product in either mode.
  function automatic int acc_width(input int n, input int data_w);
    return 2 * data_w + $clog2(n);
  endfunction

endpackage

// File: rtl/mvm_col_mac.sv
// rtl/mvm_col_mac.sv - N parallel extend-multiply-accumulate lanes, one column per cycle
module mvm_col_mac #(
  parameter int N      = 3,
  parameter int DATA_W = 8,
  parameter int ACC_W  = 18
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clear,
  input  logic                en,
  input  logic                signed_mode,
  input  logic [N*DATA_W-1:0] col_elems,
  input  logic [DATA_W-1:0]   v_elem,
  output logic [N*ACC_W-1:0]  acc
);

  logic signed [ACC_W-1:0] v_ext;
  assign v_ext = signed'({{(ACC_W-DATA_W){signed_mode & v_elem[DATA_W-1]}}, v_elem});

  for (genvar r = 0; r < N; r++) begin : g_lane
    logic [DATA_W-1:0]       m_elem;
    logic signed [ACC_W-1:0] m_ext;
    logic signed [ACC_W-1:0] prod;
    logic [ACC_W-1:0]        lane_acc;

    assign m_elem = col_elems[r*DATA_W +: DATA_W];
    assign m_ext  = signed'({{(ACC_W-DATA_W){signed_mode & m_elem[DATA_W-1]}}, m_elem});
    // Truncation to ACC_W is exact: the lane width covers the full product range.
    assign prod   = m_ext * v_ext;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        lane_acc <= '0;
      end else if (clear) begin
        lane_acc <= '0;
      end else if (en) begin
        lane_acc <= lane_acc + prod;
      end
    end

    assign acc[r*ACC_W +: ACC_W] = lane_acc;
  end

endmodule

// File: rtl/matrix_vector_mac.sv
// rtl/matrix_vector_mac.sv - column-serial N x N matrix-vector multiplier with valid/ready handshakes
module matrix_vector_mac
  import mvm_pkg::*;
#(
  parameter int N      = 3,
  parameter int DATA_W = 8,
  parameter int ACC_W  = acc_width(N, DATA_W)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  signed_mode,
  input  logic [N*N*DATA_W-1:0] matrix,
  input  logic [N*DATA_W-1:0]   vector,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [N*ACC_W-1:0]    result
);

  if (N < 2) begin : g_bad_n
    $error("matrix_vector_mac: N must be at least 2");
  end
  if (ACC_W < acc_width(N, DATA_W)) begin : g_bad_acc
    $error("matrix_vector_mac: ACC_W too small for overflow-free results");
  end

  localparam int CW = $clog2(N);

  state_t                state;
  logic [CW-1:0]         col;
  logic [N*N*DATA_W-1:0] mat_q;
  logic [N*DATA_W-1:0]   vec_q;
  logic                  mode_q;
  logic                  accept;
  logic [N*DATA_W-1:0]   col_elems;
  logic [DATA_W-1:0]     v_elem;

  assign in_ready = (state == IDLE);
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      col       <= '0;
      mat_q     <= '0;
      vec_q     <= '0;
      mode_q    <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            mat_q  <= matrix;
            vec_q  <= vector;
            mode_q <= signed_mode;
            col    <= '0;
            state  <= COMPUTE;
          end
        end
        COMPUTE: begin
          col <= col + 1'b1;
          if (col == CW'(N - 1)) begin
            state     <= DONE;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Column mux: element (r, col) for every row, plus vector element col.
  always_comb begin
    col_elems = '0;
    for (int r = 0; r < N; r++) begin
      col_elems[r*DATA_W +: DATA_W] = mat_q[(r*N + int'(col))*DATA_W +: DATA_W];
    end
  end

  assign v_elem = vec_q[int'(col)*DATA_W +: DATA_W];

  mvm_col_mac #(
    .N      (N),
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_col_mac (
    .clk         (clk),
    .rst         (rst),
    .clear       (accept),
    .en          (state == COMPUTE),
    .signed_mode (mode_q),
    .col_elems   (col_elems),
    .v_elem      (v_elem),
    .acc         (result)
  );

endmodule

// File: tb/tb_matrix_vector_mac.sv
// tb/tb_matrix_vector_mac.sv - directed self-checking bench for matrix_vector_mac at default parameters
module tb_matrix_vector_mac;

  localparam int N  = 3;
  localparam int DW = 8;
  localparam int AW = 18;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic              signed_mode;
  logic [N*N*DW-1:0] matrix;
  logic [N*DW-1:0]   vector;
  logic              out_valid;
  logic              out_ready;
  logic [N*AW-1:0]   result;

  int vectors     = 0;
  int miscompares = 0;

  matrix_vector_mac #(.N(N), .DATA_W(DW), .ACC_W(AW)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .signed_mode (signed_mode),
    .matrix      (matrix),
    .vector      (vector),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [71:0] pm(input logic [7:0] a0, a1, a2, a3, a4, a5, a6, a7, a8);
    return {a8, a7, a6, a5, a4, a3, a2, a1, a0};
  endfunction

  function automatic logic [23:0] pv(input logic [7:0] a0, a1, a2);
    return {a2, a1, a0};
  endfunction

  task automatic run_txn(input string tag, input logic sm, input logic [71:0] m,
                         input logic [23:0] v, input logic [AW-1:0] e0, e1, e2);
    int n;
    logic busy_ok;
    @(negedge clk);
    check({tag, "/idle_ready"}, 64'(in_ready), 64'd1);
    in_valid    = 1'b1;
    matrix      = m;
    vector      = v;
    signed_mode = sm;
    @(posedge clk);
    #1;
    in_valid    = 1'b0;
    matrix      = ~m;
    vector      = ~v;
    signed_mode = ~sm;
    n = 0;
    busy_ok = 1'b1;
    while (!out_valid && n < 20) begin
      if (in_ready) busy_ok = 1'b0;
      @(posedge clk);
      #1;
      n++;
    end
    check({tag, "/latency"}, 64'(n), 64'(N));
    check({tag, "/busy_not_ready"}, 64'(busy_ok), 64'd1);
    check({tag, "/lane0"}, 64'(result[0*AW +: AW]), 64'(e0));
    check({tag, "/lane1"}, 64'(result[1*AW +: AW]), 64'(e1));
    check({tag, "/lane2"}, 64'(result[2*AW +: AW]), 64'(e2));
  endtask

  task automatic handshake(input string tag);
    @(posedge clk);
    #1;
    check({tag, "/hs_valid_low"}, 64'(out_valid), 64'd0);
    check({tag, "/hs_ready_high"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    rst         = 1'b1;
    in_valid    = 1'b0;
    out_ready   = 1'b1;
    signed_mode = 1'b0;
    matrix      = '0;
    vector      = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset/in_ready", 64'(in_ready), 64'd1);
    check("reset/out_valid", 64'(out_valid), 64'd0);
    check("reset/result", 64'(result), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    run_txn("seq1", 1'b0, pm(1, 2, 3, 4, 5, 6, 7, 8, 9), pv(1, 1, 1), 18'd6, 18'd15, 18'd24);
    handshake("seq1");
    run_txn("seq2", 1'b0, pm(10, 11, 12, 13, 14, 15, 16, 17, 18), pv(2, 3, 4),
            18'd101, 18'd128, 18'd155);
    handshake("seq2");
    run_txn("seq3", 1'b0, pm(3, 6, 9, 2, 4, 8, 1, 7, 5), pv(1, 0, 1), 18'd12, 18'd10, 18'd6);
    handshake("seq3");

    run_txn("max_u", 1'b0, {9{8'hFF}}, {3{8'hFF}}, 18'h2FA03, 18'h2FA03, 18'h2FA03);
    handshake("max_u");
    run_txn("min_s", 1'b1, {9{8'h80}}, {3{8'h80}}, 18'h0C000, 18'h0C000, 18'h0C000);
    handshake("min_s");

    run_txn("mode_s", 1'b1, pm(8'hFF, 0, 0, 0, 0, 0, 0, 0, 0), pv(1, 0, 0), 18'h3FFFF, 18'd0, 18'd0);
    handshake("mode_s");
    run_txn("mode_u", 1'b0, pm(8'hFF, 0, 0, 0, 0, 0, 0, 0, 0), pv(1, 0, 0), 18'd255, 18'd0, 18'd0);
    handshake("mode_u");

    @(negedge clk);
    out_ready = 1'b0;
    run_txn("bp", 1'b0, pm(1, 2, 3, 4, 5, 6, 7, 8, 9), pv(2, 3, 4), 18'd20, 18'd47, 18'd74);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid    = 1'b1;
      matrix      = 72'({$urandom, $urandom, $urandom});
      signed_mode = ~signed_mode;
      @(posedge clk);
      #1;
      check("bp/hold_valid", 64'(out_valid), 64'd1);
      check("bp/hold_result", 64'(result), 64'({18'd74, 18'd47, 18'd20}));
      check("bp/no_accept", 64'(in_ready), 64'd0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("bp/release_valid", 64'(out_valid), 64'd0);
    check("bp/release_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    check("bp/idle_after", 64'(in_ready), 64'd1);
    check("bp/no_second_valid", 64'(out_valid), 64'd0);

    @(negedge clk);
    in_valid    = 1'b1;
    signed_mode = 1'b0;
    matrix      = pm(1, 2, 3, 4, 5, 6, 7, 8, 9);
    vector      = pv(1, 1, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_mid/out_valid", 64'(out_valid), 64'd0);
    check("rst_mid/result", 64'(result), 64'd0);
    check("rst_mid/in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    run_txn("post_rst", 1'b0, pm(10, 11, 12, 13, 14, 15, 16, 17, 18), pv(2, 3, 4),
            18'd101, 18'd128, 18'd155);
    handshake("post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
